// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU op encoding, forward selects and instruction field positions
// for the front end of the 16-bit pipelined CPU.
package cpu_pkg;
   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_PASSB, ALU_PASSA
   } alu_op_t;
   localparam logic [1:0] FWD_EX = 2'b00;
   localparam logic [1:0] FWD_WB = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam int OP_MSB  = 23;
   localparam int RD_MSB  = 19;
   localparam int RS1_MSB = 15;
   localparam int RS2_MSB = 11;
   localparam int IMM_MSB = 7;
   localparam int IMM_W   = 8;
endpackage

// File: rtl/fetch_decode_execute_regfile.sv
// regfile: REGNUM x WIDTH register file, two combinational reads, one write,
// with write-through so a same-cycle read of the write address sees the new data.
module regfile #(
   parameter int WIDTH        = 16,
   parameter int REGNUM       = 16,
   parameter int ADDRESSWIDTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    we,
   input  logic [ADDRESSWIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]        wdata,
   input  logic [ADDRESSWIDTH-1:0] raddr1,
   input  logic [ADDRESSWIDTH-1:0] raddr2,
   output logic [WIDTH-1:0]        rdata1,
   output logic [WIDTH-1:0]        rdata2
);
   logic [WIDTH-1:0] regs [REGNUM];

   always_ff @(posedge clock or negedge reset)
      if (!reset)
         regs <= '{default: '0};
      else if (we)
         regs[waddr] <= wdata;

   assign rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
   assign rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
endmodule

// File: rtl/fetch_decode_execute.sv
// fetch_decode_execute: PC/fetch, decode with register file, and ALU execute
// stages of the 16-bit CPU, including the IF/ID and ID/EX pipeline registers.
module fetch_decode_execute
   import cpu_pkg::*;
#(
   parameter int WIDTH            = 16,
   parameter int REGNUM           = 16,
   parameter int ADDRESSWIDTH     = 4,
   parameter int OPCODEWIDTH      = 4,
   parameter int INSTRUCTIONWIDTH = 24
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [INSTRUCTIONWIDTH-1:0] instr_f,
   output logic [WIDTH-1:0]            pc_f,
   input  logic                        stall_f,
   input  logic                        stall_d,
   input  logic                        flush_d,
   input  logic                        flush_e,
   input  logic                        take_branch,
   input  logic [WIDTH-1:0]            branch_target,
   input  logic                        wb_we,
   input  logic [ADDRESSWIDTH-1:0]     wb_addr,
   input  logic [WIDTH-1:0]            wb_data,
   input  logic                        pc_as_r1_d,
   input  logic [2:0]                  alu_ctrl_d,
   input  logic                        data2_sel_d,
   output logic [OPCODEWIDTH-1:0]      opcode_d,
   output logic [ADDRESSWIDTH-1:0]     rs1_d,
   output logic [ADDRESSWIDTH-1:0]     rs2_d,
   output logic [ADDRESSWIDTH-1:0]     rs1_e,
   output logic [ADDRESSWIDTH-1:0]     rs2_e,
   output logic [ADDRESSWIDTH-1:0]     rd_e,
   output logic [OPCODEWIDTH-1:0]      opcode_e,
   input  logic [WIDTH-1:0]            fwd_m,
   input  logic [WIDTH-1:0]            fwd_wb,
   input  logic [1:0]                  fwd1_sel,
   input  logic [1:0]                  fwd2_sel,
   output logic [WIDTH-1:0]            alu_out_e,
   output logic [WIDTH-1:0]            store_data_e,
   output logic                        n_e,
   output logic                        z_e,
   output logic                        v_e,
   output logic                        c_e
);
   typedef struct packed {
      logic [WIDTH-1:0]        reg1;
      logic [WIDTH-1:0]        reg2;
      logic [WIDTH-1:0]        imm;
      logic [ADDRESSWIDTH-1:0] rd;
      logic [ADDRESSWIDTH-1:0] rs1;
      logic [ADDRESSWIDTH-1:0] rs2;
      alu_op_t                 alu_ctrl;
      logic                    data2_sel;
      logic [OPCODEWIDTH-1:0]  opcode;
   } idex_t;

   logic [INSTRUCTIONWIDTH-1:0] instr_d;
   logic [WIDTH-1:0]            pc_d, rd1, rd2, imm_d;
   logic [ADDRESSWIDTH-1:0]     rd_d;
   idex_t                       ex;
   logic [WIDTH-1:0]            a, b, b_reg;
   logic [WIDTH:0]              sum, diff;

   always_ff @(posedge clock or negedge reset)
      if (!reset)
         pc_f <= '0;
      else if (take_branch)
         pc_f <= branch_target;
      else if (!stall_f)
         pc_f <= pc_f + 1'b1;

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         instr_d <= '0;
         pc_d    <= '0;
      end else if (flush_d) begin
         instr_d <= '0;
         pc_d    <= '0;
      end else if (!stall_d) begin
         instr_d <= instr_f;
         pc_d    <= pc_f;
      end

   assign opcode_d = instr_d[OP_MSB -: OPCODEWIDTH];
   assign rd_d     = instr_d[RD_MSB -: ADDRESSWIDTH];
   assign rs1_d    = instr_d[RS1_MSB -: ADDRESSWIDTH];
   assign rs2_d    = instr_d[RS2_MSB -: ADDRESSWIDTH];
   assign imm_d    = {{(WIDTH-IMM_W){instr_d[IMM_MSB]}}, instr_d[IMM_MSB -: IMM_W]};

   regfile #(.WIDTH(WIDTH), .REGNUM(REGNUM), .ADDRESSWIDTH(ADDRESSWIDTH)) u_rf (
      .clock (clock),
      .reset (reset),
      .we    (wb_we),
      .waddr (wb_addr),
      .wdata (wb_data),
      .raddr1(rs1_d),
      .raddr2(rs2_d),
      .rdata1(rd1),
      .rdata2(rd2)
   );

   always_ff @(posedge clock or negedge reset)
      if (!reset)
         ex <= '0;
      else if (flush_e)
         ex <= '0;
      else
         ex <= '{reg1: pc_as_r1_d ? pc_d : rd1, reg2: rd2, imm: imm_d, rd: rd_d,
                 rs1: rs1_d, rs2: rs2_d, alu_ctrl: alu_op_t'(alu_ctrl_d),
                 data2_sel: data2_sel_d, opcode: opcode_d};

   assign rs1_e    = ex.rs1;
   assign rs2_e    = ex.rs2;
   assign rd_e     = ex.rd;
   assign opcode_e = ex.opcode;

   // Select 11 falls back to the ID/EX value, same as 00.
   assign a     = fwd1_sel == FWD_WB ? fwd_wb : fwd1_sel == FWD_M ? fwd_m : ex.reg1;
   assign b_reg = fwd2_sel == FWD_WB ? fwd_wb : fwd2_sel == FWD_M ? fwd_m : ex.reg2;
   assign b     = ex.data2_sel ? ex.imm : b_reg;
   assign store_data_e = b_reg;

   // Subtraction as A + ~B + 1 so the carry-out is the inverted borrow.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} + {1'b0, ~b} + 1'b1;

   always_comb begin
      alu_out_e = '0;
      c_e = 1'b0;
      v_e = 1'b0;
      unique case (ex.alu_ctrl)
         ALU_ADD: begin
            alu_out_e = sum[WIDTH-1:0];
            c_e = sum[WIDTH];
            v_e = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_out_e = diff[WIDTH-1:0];
            c_e = diff[WIDTH];
            v_e = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND:   alu_out_e = a & b;
         ALU_OR:    alu_out_e = a | b;
         ALU_XOR:   alu_out_e = a ^ b;
         ALU_SHL:   alu_out_e = a << b[3:0];
         ALU_PASSB: alu_out_e = b;
         ALU_PASSA: alu_out_e = a;
         default:   alu_out_e = '0;
      endcase
   end

   assign n_e = alu_out_e[WIDTH-1];
   assign z_e = alu_out_e == '0;
endmodule

// File: tb/tb_fetch_decode_execute.sv
// tb_fetch_decode_execute: directed checks of fetch, decode, register file,
// forwarding, ALU flags and hazard controls with hand-computed expectations.
module tb_fetch_decode_execute;
   logic        clock = 1'b0, reset = 1'b0;
   logic [23:0] instr_f = '0;
   logic [15:0] pc_f, branch_target = '0, wb_data = '0, fwd_m = '0, fwd_wb = '0;
   logic        stall_f = 0, stall_d = 0, flush_d = 0, flush_e = 0, take_branch = 0;
   logic        wb_we = 0, pc_as_r1_d = 0, data2_sel_d = 0;
   logic [3:0]  wb_addr = '0, opcode_d, rs1_d, rs2_d, rs1_e, rs2_e, rd_e, opcode_e;
   logic [2:0]  alu_ctrl_d = '0;
   logic [1:0]  fwd1_sel = '0, fwd2_sel = '0;
   logic [15:0] alu_out_e, store_data_e;
   logic        n_e, z_e, v_e, c_e;
   int          n_cmp = 0, n_err = 0;
   logic [15:0] logic_exp [8];

   fetch_decode_execute dut (
      .clock(clock), .reset(reset), .instr_f(instr_f), .pc_f(pc_f),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .take_branch(take_branch), .branch_target(branch_target),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .pc_as_r1_d(pc_as_r1_d), .alu_ctrl_d(alu_ctrl_d), .data2_sel_d(data2_sel_d),
      .opcode_d(opcode_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .opcode_e(opcode_e), .fwd_m(fwd_m), .fwd_wb(fwd_wb),
      .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .alu_out_e(alu_out_e),
      .store_data_e(store_data_e), .n_e(n_e), .z_e(z_e), .v_e(v_e), .c_e(c_e)
   );

   initial forever #5 clock = ~clock;

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic_exp[2] = 16'h0001; logic_exp[3] = 16'h0FF7; logic_exp[4] = 16'h0FF6;
      logic_exp[5] = 16'h1E60; logic_exp[6] = 16'h0F05; logic_exp[7] = 16'h00F3;
      #12;
      chk("rst_pc", pc_f, 0);
      chk("rst_alu", alu_out_e, 0);
      chk("rst_z", z_e, 1);
      tick(); reset = 1; #1;
      chk("cnt0", pc_f, 0);
      tick(); chk("cnt1", pc_f, 1);
      tick(); chk("cnt2", pc_f, 2);
      // branch wins over stall_f
      stall_f = 1; take_branch = 1; branch_target = 16'h0040;
      tick(); chk("br_stall", pc_f, 16'h0040);
      take_branch = 0;
      tick(); chk("stall_hold", pc_f, 16'h0040);
      stall_f = 0;
      tick(); chk("unstall", pc_f, 16'h0041);
      take_branch = 1; branch_target = 16'hFFFF;
      tick(); take_branch = 0; #1;
      chk("br_ffff", pc_f, 16'hFFFF);
      tick(); chk("pc_wrap", pc_f, 0);
      // write-through bypass on R3
      instr_f = 24'h253000;
      tick(); chk("dec_op", opcode_d, 2); chk("dec_rs1", rs1_d, 3); chk("dec_rs2", rs2_d, 0);
      wb_we = 1; wb_addr = 3; wb_data = 16'h1234; alu_ctrl_d = 3'd7; data2_sel_d = 0;
      stall_d = 1; instr_f = 24'h9AB000;
      tick(); chk("bypass", alu_out_e, 16'h1234); chk("rs1_e", rs1_e, 3); chk("rd_e", rd_e, 5);
      wb_we = 0;
      tick(); chk("r3_stored", alu_out_e, 16'h1234); chk("stall_d2", opcode_d, 2);
      chk("stall_d2_rs1", rs1_d, 3);
      stall_d = 0;
      // R5 = 5, then add imm -1 with forwarding variants
      wb_we = 1; wb_addr = 5; wb_data = 16'h0005; instr_f = 24'h1650FF;
      tick(); wb_we = 0; alu_ctrl_d = 3'd0; data2_sel_d = 1;
      tick();
      chk("fwd00", alu_out_e, 4); chk("fwd00_c", c_e, 1);
      chk("op_e", opcode_e, 1); chk("rd_e6", rd_e, 6);
      fwd1_sel = 2'b10; fwd_m = 16'h0007; #1;
      chk("fwd_m", alu_out_e, 6); chk("fwd_m_c", c_e, 1);
      fwd1_sel = 2'b01; fwd_wb = 16'h0009; #1;
      chk("fwd_wb", alu_out_e, 8);
      fwd1_sel = 2'b11; #1;
      chk("fwd11", alu_out_e, 4);
      // flags via forwarded operands
      fwd1_sel = 0; data2_sel_d = 0; alu_ctrl_d = 3'd0;
      tick();
      fwd1_sel = 2'b10; fwd2_sel = 2'b01; fwd_m = 16'h7FFF; fwd_wb = 16'h0001; #1;
      chk("ovf_res", alu_out_e, 16'h8000); chk("ovf_n", n_e, 1); chk("ovf_v", v_e, 1);
      chk("ovf_c", c_e, 0); chk("ovf_z", z_e, 0); chk("store", store_data_e, 1);
      alu_ctrl_d = 3'd1;
      tick(); fwd_m = 16'h0003; fwd_wb = 16'h0003; #1;
      chk("sub_z", z_e, 1); chk("sub_c", c_e, 1); chk("sub_v", v_e, 0);
      fwd_m = 16'h0002; fwd_wb = 16'h0005; #1;
      chk("sub_neg", alu_out_e, 16'hFFFD); chk("sub_borrow", c_e, 0); chk("sub_n", n_e, 1);
      fwd_m = 16'h8000; fwd_wb = 16'h0001; #1;
      chk("sub_ovf", alu_out_e, 16'h7FFF); chk("sub_ovf_v", v_e, 1); chk("sub_ovf_c", c_e, 1);
      fwd_m = 16'h00F3; fwd_wb = 16'h0F05;
      for (int k = 2; k < 8; k++) begin
         alu_ctrl_d = 3'(k);
         tick();
         chk($sformatf("alu%0d", k), alu_out_e, logic_exp[k]);
         chk($sformatf("alu%0d_cv", k), {c_e, v_e}, 0);
      end
      // hazard controls
      fwd1_sel = 0; fwd2_sel = 0; data2_sel_d = 1; alu_ctrl_d = 3'd0; flush_e = 1;
      tick(); chk("flush_e_op", opcode_e, 0); chk("flush_e_rd", rd_e, 0);
      flush_e = 0;
      tick(); chk("refill_op", opcode_e, 1); chk("refill_rd", rd_e, 6); chk("refill_alu", alu_out_e, 4);
      flush_d = 1; stall_d = 1;
      tick(); chk("flush_d_op", opcode_d, 0); chk("flush_d_rs1", rs1_d, 0);
      flush_d = 0; stall_d = 0;
      // asynchronous reset mid-cycle
      #2 reset = 0; #1;
      chk("mid_rst_pc", pc_f, 0); chk("mid_rst_alu", alu_out_e, 0);
      chk("mid_rst_z", z_e, 1); chk("mid_rst_op", opcode_e, 0);
      #10 reset = 1;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
